// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - loader states and stream framing constants; CHECK exists only with PROGRAM_LOADER_CHECKSUM_EN
package loader_pkg;

  // Length header is a little-endian 16-bit word count
  localparam int HEADER_BYTES   = 2;
  // Instruction words arrive as four little-endian bytes
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_LO = 3'd1,
    LEN_HI = 3'd2,
    DATA   = 3'd3,
    WRITE  = 3'd4,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    CHECK  = 3'd5,
`endif
    DONE   = 3'd6,
    ERROR  = 3'd7
  } state_t;

endpackage

// File: rtl/program_loader_if.sv
// rtl/program_loader_if.sv - serial byte stream and program memory write bus of the loader
interface program_loader_if;

  logic        rx_valid_i;
  logic [7:0]  rx_data_i;
  logic        rx_ready_o;
  logic        Mem_Write_o;
  logic [31:0] Address_o;
  logic [31:0] Write_Data_o;

  // Byte source and memory observer side
  modport master (
    output rx_valid_i, rx_data_i,
    input  rx_ready_o, Mem_Write_o, Address_o, Write_Data_o
  );

  // Loader side
  modport slave (
    input  rx_valid_i, rx_data_i,
    output rx_ready_o, Mem_Write_o, Address_o, Write_Data_o
  );

endinterface

// File: rtl/loader_word_assembler.sv
// rtl/loader_word_assembler.sv - four-byte little-endian shift register with byte count and word-complete flag
module loader_word_assembler
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_data_i,
  output logic [31:0] word_o,
  output logic        word_complete_o
);

  localparam int CNT_W = $clog2(BYTES_PER_WORD);

  logic [31:0]      shift_q;
  logic [CNT_W-1:0] count_q;

  // word_o already includes the byte on the input, so the caller can latch it on the final byte's edge
  assign word_o          = {byte_data_i, shift_q[31:8]};
  assign word_complete_o = byte_valid_i && (count_q == CNT_W'(BYTES_PER_WORD - 1));

  // Bytes enter at the top so the first byte of a word ends up in bits 7:0
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_q <= '0;
      count_q <= '0;
    end else if (clear_i) begin
      shift_q <= '0;
      count_q <= '0;
    end else if (byte_valid_i) begin
      shift_q <= word_o;
      count_q <= word_complete_o ? '0 : count_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/program_loader.sv
// rtl/program_loader.sv - serial program loader into instruction memory; checksum stage under PROGRAM_LOADER_CHECKSUM_EN
module program_loader
  import loader_pkg::*;
#(
  parameter int PROGRAM_MEMORY_DEPTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  program_loader_if.slave  bus,
  output logic             Core_Reset_o,
  output logic             Done_o,
  output logic             Error_o
);

  localparam int IDX_W = $clog2(PROGRAM_MEMORY_DEPTH + 1);
  localparam int LEN_W = 8 * HEADER_BYTES;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  localparam state_t AFTER_DATA = CHECK;
`else
  localparam state_t AFTER_DATA = DONE;
`endif

  state_t           state_q, state_d;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] len_full;
  logic [IDX_W-1:0] idx_q;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic [31:0]      asm_word;
  logic             asm_complete;
  logic             rx_fire;
  logic             data_fire;
  logic             start_ok;
  logic             len_too_big;
  logic             len_zero;
  logic             more_words;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0]       sum_q;
`endif

  assign rx_fire     = bus.rx_valid_i && bus.rx_ready_o;
  assign data_fire   = rx_fire && (state_q == DATA);
  assign start_ok    = start_i && ((state_q == IDLE) || (state_q == DONE) || (state_q == ERROR));
  assign len_full    = {bus.rx_data_i, len_q[7:0]};
  assign len_too_big = int'(len_full) > PROGRAM_MEMORY_DEPTH;
  assign len_zero    = (len_full == '0);
  assign more_words  = (int'(idx_q) + 1) < int'(len_q);

  assign bus.rx_ready_o   = (state_q == LEN_LO) || (state_q == LEN_HI) || (state_q == DATA)
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                            || (state_q == CHECK)
`endif
                            ;
  assign bus.Mem_Write_o  = (state_q == WRITE);
  assign bus.Address_o    = addr_q;
  assign bus.Write_Data_o = wdata_q;
  assign Core_Reset_o     = (state_q == DONE);
  assign Done_o           = (state_q == DONE);
  assign Error_o          = (state_q == ERROR);

  loader_word_assembler u_asm (
    .clk             (clk),
    .reset           (reset),
    .clear_i         (start_ok),
    .byte_valid_i    (data_fire),
    .byte_data_i     (bus.rx_data_i),
    .word_o          (asm_word),
    .word_complete_o (asm_complete)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state: header, data words with a write slot after each, optional checksum byte
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE, ERROR: if (start_i) state_d = LEN_LO;
      LEN_LO:            if (rx_fire) state_d = LEN_HI;
      LEN_HI: begin
        if (rx_fire) begin
          if (len_too_big)   state_d = ERROR;
          else if (len_zero) state_d = AFTER_DATA;
          else               state_d = DATA;
        end
      end
      DATA:              if (data_fire && asm_complete) state_d = WRITE;
      WRITE:             state_d = more_words ? DATA : AFTER_DATA;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      CHECK:             if (rx_fire) state_d = (bus.rx_data_i == sum_q) ? DONE : ERROR;
`endif
      default:           state_d = IDLE;
    endcase
  end

  // Length, word index, write bus and checksum; write bus keeps its last values across loads
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len_q   <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      if (start_ok) begin
        len_q <= '0;
        idx_q <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        sum_q <= '0;
`endif
      end
      if (rx_fire && (state_q == LEN_LO)) len_q[7:0] <= bus.rx_data_i;
      if (rx_fire && (state_q == LEN_HI)) len_q      <= len_full;
      if (data_fire && asm_complete) begin
        addr_q  <= 32'(idx_q) << 2;
        wdata_q <= asm_word;
      end
      if (state_q == WRITE) idx_q <= idx_q + IDX_W'(1);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      if (data_fire) sum_q <= sum_q + bus.rx_data_i;
`endif
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - self-checking bench for program_loader (checksum cases under PROGRAM_LOADER_CHECKSUM_EN)
module tb_program_loader;
  import loader_pkg::*;

  localparam int DEPTH = 64;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  localparam bit CKS_EN = 1'b1;
`else
  localparam bit CKS_EN = 1'b0;
`endif

  typedef struct {
    int         n;
    int         idle;
    logic [7:0] cks_xor;
    bit         exp_done;
    int         exp_writes;
  } vec_t;

  logic clk     = 1'b0;
  logic reset   = 1'b0;
  logic start_i = 1'b0;
  logic core_reset, done, error;

  program_loader_if bus ();

  program_loader #(.PROGRAM_MEMORY_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .start_i      (start_i),
    .bus          (bus.slave),
    .Core_Reset_o (core_reset),
    .Done_o       (done),
    .Error_o      (error)
  );

  always #5 clk = ~clk;

  int          compared   = 0;
  int          mismatched = 0;
  int          wr_seen    = 0;
  logic [31:0] stim_words[$];
  vec_t        tbl[$];

  // Count every cycle the write strobe is seen high
  always @(negedge clk) if (bus.Mem_Write_o === 1'b1) wr_seen++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, want finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // Offer one byte after a random number of idle cycles; returns on the negedge after the transfer
  task automatic send_byte(input logic [7:0] b, input int idle_pct);
    int guard;
    guard = 0;
    while (idle_pct > 0 && int'($urandom_range(99)) < idle_pct && guard < 6) begin
      bus.rx_valid_i = 1'b0;
      bus.rx_data_i  = 8'($urandom);
      @(negedge clk);
      guard++;
    end
    bus.rx_valid_i = 1'b1;
    bus.rx_data_i  = b;
    guard = 0;
    while (bus.rx_ready_o !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (bus.rx_ready_o !== 1'b1) begin
      compared++;
      mismatched++;
      $display("FAIL rx_ready_timeout: got rx_ready_o=%b after 20 cycles, want 1", bus.rx_ready_o);
      bus.rx_valid_i = 1'b0;
      return;
    end
    @(negedge clk);
    bus.rx_valid_i = 1'b0;
  endtask

  // One complete load; the model derives addresses, data and final status from the word list
  task automatic run_load(input int n, input int idle, input logic [7:0] cks_xor,
                          input int glitch_at, input bit fixed, input bit exp_done,
                          input int exp_writes);
    int          base;
    int          nw;
    int          k;
    bit          model_done;
    logic [31:0] w;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0]  sum;
`endif
    base = wr_seen;
    nw   = (n > DEPTH) ? 0 : n;
    if (!fixed) begin
      stim_words.delete();
      for (int i = 0; i < nw; i++) stim_words.push_back($urandom);
    end
    model_done = (n <= DEPTH) && (!CKS_EN || cks_xor == 8'h00);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    sum = 8'h00;
    for (int i = 0; i < nw; i++)
      sum = sum + stim_words[i][7:0] + stim_words[i][15:8] + stim_words[i][23:16] + stim_words[i][31:24];
`endif

    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    check("start_done_low", 32'(done), 32'd0);
    check("start_error_low", 32'(error), 32'd0);
    check("start_core_reset_low", 32'(core_reset), 32'd0);

    send_byte(n[7:0], idle);
    send_byte(n[15:8], idle);

    k = 0;
    for (int i = 0; i < nw; i++) begin
      w = stim_words[i];
      for (int j = 0; j < 4; j++) begin
        if (k == glitch_at) begin
          start_i = 1'b1;
          @(negedge clk);
          start_i = 1'b0;
        end
        send_byte(w[8*j +: 8], idle);
        k++;
      end
      check("write_strobe", 32'(bus.Mem_Write_o), 32'd1);
      check("write_ready_low", 32'(bus.rx_ready_o), 32'd0);
      check("write_addr", bus.Address_o, 32'(4 * i));
      check("write_data", bus.Write_Data_o, w);
      @(negedge clk);
    end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    if (n <= DEPTH) send_byte(sum ^ cks_xor, idle);
`endif

    check("final_done", 32'(done), 32'(exp_done));
    check("final_error", 32'(error), 32'(!exp_done));
    check("final_core_reset", 32'(core_reset), 32'(model_done));
    check("final_ready_low", 32'(bus.rx_ready_o), 32'd0);
    check("write_count", 32'(wr_seen - base), 32'(exp_writes));
    check("model_write_count", 32'(wr_seen - base), 32'(nw));
    if (nw > 0) begin
      check("hold_addr", bus.Address_o, 32'(4 * (nw - 1)));
      check("hold_data", bus.Write_Data_o, stim_words[nw-1]);
    end
  endtask

  initial begin
    bus.rx_valid_i = 1'b0;
    bus.rx_data_i  = 8'h00;

    // Reset state
    #12;
    check("rst_core_reset", 32'(core_reset), 32'd0);
    check("rst_ready", 32'(bus.rx_ready_o), 32'd0);
    check("rst_mem_write", 32'(bus.Mem_Write_o), 32'd0);
    check("rst_addr", bus.Address_o, 32'd0);
    check("rst_wdata", bus.Write_Data_o, 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("idle_ready_low", 32'(bus.rx_ready_o), 32'd0);
    check("idle_core_reset_low", 32'(core_reset), 32'd0);

    // Two known instructions
    stim_words = '{32'h0000_0013, 32'h0010_0093};
    run_load(2, 0, 8'h00, -1, 1'b1, 1'b1, 2);

    // Randomised loads, including the depth boundary and oversize headers
    tbl.push_back('{1, 0, 8'h00, 1'b1, 1});
    tbl.push_back('{3, 50, 8'h00, 1'b1, 3});
    tbl.push_back('{0, 0, 8'h00, 1'b1, 0});
    tbl.push_back('{64, 20, 8'h00, 1'b1, 64});
    tbl.push_back('{65, 0, 8'h00, 1'b0, 0});
    tbl.push_back('{5, 70, 8'h00, 1'b1, 5});
    tbl.push_back('{65535, 0, 8'h00, 1'b0, 0});
    tbl.push_back('{3, 40, 8'h00, 1'b1, 3});
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    tbl.push_back('{2, 30, 8'h5A, 1'b0, 2});
    tbl.push_back('{0, 0, 8'h01, 1'b0, 0});
`endif
    foreach (tbl[t]) run_load(tbl[t].n, tbl[t].idle, tbl[t].cks_xor, -1, 1'b0, tbl[t].exp_done, tbl[t].exp_writes);

    // start_i pulsed mid-data is ignored
    run_load(2, 0, 8'h00, 2, 1'b0, 1'b1, 2);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    stim_words = '{32'h0000_0013};
    run_load(1, 0, 8'h00, -1, 1'b1, 1'b1, 1);
    run_load(1, 0, 8'h07, -1, 1'b1, 1'b0, 1);
`endif

    // Reset mid-load discards the partial word
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    reset = 1'b0;
    #1;
    check("midrst_ready", 32'(bus.rx_ready_o), 32'd0);
    check("midrst_addr", bus.Address_o, 32'd0);
    check("midrst_wdata", bus.Write_Data_o, 32'd0);
    check("midrst_core_reset", 32'(core_reset), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    stim_words = '{32'hCAFE_0042};
    run_load(1, 0, 8'h00, -1, 1'b1, 1'b1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter PROGRAM_MEMORY_DEPTH, default 64, meaning program memory capacity in 32-bit words.
REQ-002 SHALL have port clk  input  1  single system clock, all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start_i  input  1  one-cycle request to begin a load.
REQ-005 SHALL have port rx_valid_i  input  1  serial byte available.
REQ-006 SHALL have port rx_data_i  input  8  serial byte.
REQ-007 SHALL have port rx_ready_o  output  1  loader accepts byte; transfer occurs when rx_valid_i and rx_ready_o are both high on a clock edge.
REQ-008 SHALL have port Mem_Write_o  output  1  program memory write strobe.
REQ-009 SHALL have port Address_o  output  32  program memory byte address.
REQ-010 SHALL have port Write_Data_o  output  32  instruction word to write.
REQ-011 SHALL have port Core_Reset_o  output  1  active-low reset to the processor core; low holds the core.
REQ-012 SHALL have port Done_o  output  1  load completed successfully.
REQ-013 SHALL have port Error_o  output  1  load aborted.

Function
REQ-014 SHALL implement states IDLE, LEN_LO, LEN_HI, DATA, WRITE, CHECK, DONE, ERROR.
REQ-015 SHALL leave IDLE, DONE or ERROR for LEN_LO on start_i; clear Done_o and Error_o; drive Core_Reset_o low.
REQ-016 SHALL ignore start_i in every other state.
REQ-017 SHALL interpret the stream as: word count N (16-bit, LEN_LO byte first), then N words, each 4 bytes little-endian.
REQ-018 SHALL drive rx_ready_o high only in LEN_LO, LEN_HI, DATA and CHECK.
REQ-019 SHALL go to ERROR after LEN_HI if N > PROGRAM_MEMORY_DEPTH.
REQ-020 SHALL go after LEN_HI with N == 0 to CHECK if checksum is enabled, otherwise to DONE.
REQ-021 SHALL go to WRITE on the fourth byte of each word accepted in DATA.
REQ-022 SHALL in WRITE assert Mem_Write_o for exactly one cycle, with Write_Data_o = assembled word and Address_o = 4 x word index starting at 0.
REQ-023 SHALL after WRITE return to DATA if words remain, else go to CHECK (or DONE if disabled).
REQ-024 SHALL produce a write one cycle after the last byte of each word is accepted, with rx_ready_o low during that cycle.
REQ-025 SHALL hold Address_o and Write_Data_o stable outside WRITE at their last values.
REQ-026 SHALL in DONE hold Done_o high and Core_Reset_o high; SHALL in ERROR hold Error_o high and Core_Reset_o low.
REQ-027 SHALL perform address arithmetic in 32 bits, word index counter ceil(log2(PROGRAM_MEMORY_DEPTH+1)) bits, with no wrap beyond N.

Reset
REQ-028 SHALL on reset low immediately force IDLE, Core_Reset_o=0, rx_ready_o=0, Mem_Write_o=0, Address_o=0, Write_Data_o=0, Done_o=0, Error_o=0, clear counters and checksum, including mid-load; partial words SHALL be discarded.

Configuration
REQ-029 SHALL compile checksum support when macro PROGRAM_LOADER_CHECKSUM_EN is defined: accumulate the 8-bit modulo-256 sum of all data bytes (not header); in CHECK accept one byte and go to DONE if equal, else ERROR.
REQ-030 SHALL, without PROGRAM_LOADER_CHECKSUM_EN, contain no CHECK state or accumulator logic; the last WRITE goes directly to DONE.

Structure
REQ-031 SHALL place the state enumeration, header length constant (2 bytes) and bytes-per-word constant (4) in shared package loader_pkg.
REQ-032 SHALL use one sub-module, loader_word_assembler: 4-byte little-endian shift register with byte count and word-complete flag.

Verification
REQ-033 SHALL verify: N=2, bytes 13 00 00 00, 93 00 10 00 -> writes 0x00000013 @0x0 and 0x00100093 @0x4, then Done_o=1 and Core_Reset_o=1.
REQ-034 SHALL verify: N=65 with depth 64 -> Error_o=1 after LEN_HI, no Mem_Write_o pulse, Core_Reset_o=0.
REQ-035 SHALL verify: rx_valid_i toggled randomly in DATA for N=3 -> exactly 3 single-cycle writes at 0x0, 0x4, 0x8 with correct data, each one cycle after the fourth byte.
REQ-036 SHALL verify with the macro defined: N=1, word 0x00000013 with checksum 0x13 -> DONE; with checksum 0x14 -> ERROR.
REQ-037 SHALL verify: reset asserted after 2 data bytes, then reloaded N=1 -> the first write is @0x0 with only the new bytes.
REQ-038 SHALL verify: start_i pulsed in DATA -> ignored; N=0 -> DONE with no writes.
